// File: rtl/dii_package.sv
// Shared debug-interconnect types: flit format, ring demux states, address width.
package dii_package;

   localparam int DII_ADDR_WIDTH = 16;

   typedef struct packed {
      logic        valid;
      logic        last;
      logic [15:0] data;
   } dii_flit;

   typedef enum logic [1:0] {
      IDLE,
      WORM_LOCAL,
      WORM_RING
   } ring_demux_state_t;

endpackage

// File: rtl/dii_skid_buffer.sv
// Two-entry elastic buffer for dii_flit; output side is driven purely from registers.
module dii_skid_buffer
   import dii_package::*;
(
   input  logic    clk,
   input  logic    rst,
   input  dii_flit up,
   output logic    up_ready,
   output dii_flit down,
   input  logic    down_ready
);

   logic [1:0][16:0] mem;
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             push;
   logic             pop;

   // Accept whenever a slot is free, so a full-rate stream survives a one-cycle stall.
   assign up_ready = (count != 2'd2);
   assign push     = up.valid & up_ready;
   assign pop      = down.valid & down_ready;

   always_comb begin
      down.valid = (count != 2'd0);
      down.last  = mem[rd_ptr][16];
      down.data  = mem[rd_ptr][15:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {up.last, up.data};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: rtl/ring_router_demux.sv
// Ingress demux of the debug ring router: steers each worm to the local port or along the ring.
// Define RING_ROUTER_DEMUX_OUTREG_EN to register both outputs through skid buffers.
module ring_router_demux
   import dii_package::*;
#(
   parameter logic [DII_ADDR_WIDTH-1:0] ID = 16'h0000
)(
   input  logic    clk,
   input  logic    rst,
   input  dii_flit in_ring,
   output logic    in_ring_ready,
   output dii_flit out_local,
   input  logic    out_local_ready,
   output dii_flit out_ring,
   input  logic    out_ring_ready
);

   ring_demux_state_t state, state_nxt;
   dii_flit           fwd_local;
   dii_flit           fwd_ring;
   logic              fwd_local_ready;
   logic              fwd_ring_ready;
   logic              sel_local;
   logic              xfer;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Destination is only decoded in IDLE; inside a worm the locked port wins regardless of data.
   always_comb begin
      sel_local = 1'b0;
      case (state)
         IDLE:       sel_local = (in_ring.data == ID);
         WORM_LOCAL: sel_local = 1'b1;
         default:    sel_local = 1'b0;
      endcase

      fwd_local       = in_ring;
      fwd_local.valid = in_ring.valid & sel_local & rst;
      fwd_ring        = in_ring;
      fwd_ring.valid  = in_ring.valid & ~sel_local & rst;

      in_ring_ready = rst & (sel_local ? fwd_local_ready : fwd_ring_ready);
      xfer          = in_ring.valid & in_ring_ready;

      state_nxt = state;
      case (state)
         IDLE:
            if (xfer && !in_ring.last)
               state_nxt = sel_local ? WORM_LOCAL : WORM_RING;
         WORM_LOCAL, WORM_RING:
            if (xfer && in_ring.last)
               state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

`ifdef RING_ROUTER_DEMUX_OUTREG_EN
   dii_skid_buffer u_local_buf (
      .clk        (clk),
      .rst        (rst),
      .up         (fwd_local),
      .up_ready   (fwd_local_ready),
      .down       (out_local),
      .down_ready (out_local_ready)
   );

   dii_skid_buffer u_ring_buf (
      .clk        (clk),
      .rst        (rst),
      .up         (fwd_ring),
      .up_ready   (fwd_ring_ready),
      .down       (out_ring),
      .down_ready (out_ring_ready)
   );
`else
   assign out_local       = fwd_local;
   assign out_ring        = fwd_ring;
   assign fwd_local_ready = out_local_ready;
   assign fwd_ring_ready  = out_ring_ready;
`endif

endmodule

// File: tb/tb_ring_router_demux.sv
// Bench for ring_router_demux (ID=5): directed cases plus a random worm scoreboard.
module tb_ring_router_demux;
   import dii_package::*;

   localparam logic [15:0] MY_ID = 16'h0005;

   logic    clk;
   logic    rst;
   dii_flit in_ring;
   logic    in_ring_ready;
   dii_flit out_local;
   logic    out_local_ready;
   dii_flit out_ring;
   logic    out_ring_ready;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      logic        last;
      logic [15:0] data;
   } exp_t;

   dii_flit stim_q[$];
   exp_t    exp_l[$];
   exp_t    exp_r[$];

   ring_router_demux #(.ID(MY_ID)) dut (
      .clk             (clk),
      .rst             (rst),
      .in_ring         (in_ring),
      .in_ring_ready   (in_ring_ready),
      .out_local       (out_local),
      .out_local_ready (out_local_ready),
      .out_ring        (out_ring),
      .out_ring_ready  (out_ring_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input logic v, input logic l, input logic [15:0] d,
                        input logic lr, input logic rr);
      in_ring.valid   = v;
      in_ring.last    = l;
      in_ring.data    = d;
      out_local_ready = lr;
      out_ring_ready  = rr;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected routing of the currently presented flit: local / ring valid and input ready.
   task automatic chk_route(input string tag, input logic lv, input logic rv, input logic rdy);
      chk({tag, "_lv"}, 32'(out_local.valid), 32'(lv));
      chk({tag, "_rv"}, 32'(out_ring.valid), 32'(rv));
      chk({tag, "_rdy"}, 32'(in_ring_ready), 32'(rdy));
   endtask

   initial begin
      int          n_loc;
      int          n_rng;
      int          idx;
      int          cyc;
      bit          pres;
      bit          acc;
      exp_t        e;
      logic [15:0] dest;
      int          len;
      logic [15:0] t4_data[5];
      logic        t4_last[5];

      // Reset state: everything quiet even with a valid flit presented.
      rst = 1'b0;
      drive(1'b1, 1'b1, MY_ID, 1'b1, 1'b1);
      #1;
      chk_route("reset", 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      #2 rst = 1'b1;

      // 1: single-flit local packet, zero latency, FSM stays in IDLE.
      drive(1'b1, 1'b1, 16'h0005, 1'b1, 1'b1);
      chk_route("t1", 1'b1, 1'b0, 1'b1);
      chk("t1_data", 32'(out_local.data), 32'h0005);
      chk("t1_fanout", 32'({out_ring.last, out_ring.data}), 32'({1'b1, 16'h0005}));
      tick();
      drive(1'b1, 1'b1, 16'h0007, 1'b1, 1'b1);
      chk_route("t1_idle", 1'b0, 1'b1, 1'b1);
      tick();

      // 2: three-flit ring worm whose body carries the local address.
      drive(1'b1, 1'b0, 16'h0007, 1'b1, 1'b1);
      chk_route("t2_f0", 1'b0, 1'b1, 1'b1);
      tick();
      drive(1'b1, 1'b0, 16'h0005, 1'b1, 1'b1);
      chk_route("t2_f1", 1'b0, 1'b1, 1'b1);
      tick();
      drive(1'b1, 1'b1, 16'h0005, 1'b1, 1'b1);
      chk_route("t2_f2", 1'b0, 1'b1, 1'b1);
      chk("t2_last", 32'(out_ring.last), 32'd1);
      tick();
      drive(1'b1, 1'b1, 16'h0005, 1'b1, 1'b1);
      chk_route("t2_idle", 1'b1, 1'b0, 1'b1);
      tick();

      // 3: local header stalled 4 cycles; unselected ready must not leak through.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 16'h0005, 1'b0, 1'b1);
         chk_route("t3_stall", 1'b1, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 1'b0, 16'h0005, 1'b1, 1'b1);
      chk_route("t3_accept", 1'b1, 1'b0, 1'b1);
      tick();
      drive(1'b1, 1'b1, 16'h0009, 1'b1, 1'b0);
      chk_route("t3_locked", 1'b1, 1'b0, 1'b1);
      tick();

      // 4: ring worm then local worm back to back, no bubble.
      t4_data = '{16'h0009, 16'h1234, 16'h0005, 16'h0005, 16'h0009};
      t4_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      n_loc = 0;
      n_rng = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, t4_last[i], t4_data[i], 1'b1, 1'b1);
         chk("t4_rdy", 32'(in_ring_ready), 32'd1);
         if (out_local.valid && out_local_ready) n_loc++;
         if (out_ring.valid && out_ring_ready) n_rng++;
         tick();
      end
      chk("t4_ring_cnt", 32'(n_rng), 32'd3);
      chk("t4_local_cnt", 32'(n_loc), 32'd2);

      // 5: asynchronous reset in the middle of a local worm.
      drive(1'b1, 1'b0, 16'h0005, 1'b1, 1'b1);
      tick();
      drive(1'b1, 1'b0, 16'h0003, 1'b1, 1'b1);
      chk_route("t5_worm", 1'b1, 1'b0, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk_route("t5_rst", 1'b0, 1'b0, 1'b0);
      tick();
      #2 rst = 1'b1;
      drive(1'b1, 1'b1, 16'h0009, 1'b1, 1'b1);
      chk_route("t5_after", 1'b0, 1'b1, 1'b1);
      tick();
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      tick();

      // 6: random worms with random backpressure against a per-port scoreboard.
      for (int w = 0; w < 1000; w++) begin
         dest = ($urandom_range(0, 1) != 0) ? MY_ID : 16'($urandom);
         len  = $urandom_range(1, 4);
         for (int f = 0; f < len; f++) begin
            dii_flit s;
            s.valid = 1'b1;
            s.last  = (f == len - 1);
            s.data  = (f == 0) ? dest : 16'($urandom);
            stim_q.push_back(s);
            e.last = s.last;
            e.data = s.data;
            if (dest == MY_ID) exp_l.push_back(e);
            else               exp_r.push_back(e);
         end
      end

      idx  = 0;
      cyc  = 0;
      pres = 1'b0;
      while ((idx < stim_q.size() || exp_l.size() != 0 || exp_r.size() != 0) && cyc < 40000) begin
         cyc++;
         out_local_ready = ($urandom_range(0, 3) != 0);
         out_ring_ready  = ($urandom_range(0, 3) != 0);
         if (idx < stim_q.size()) begin
            if (!pres) pres = ($urandom_range(0, 4) != 0);
            if (pres) in_ring = stim_q[idx];
            else begin
               in_ring.valid = 1'b0;
               in_ring.last  = 1'($urandom);
               in_ring.data  = 16'($urandom);
            end
         end else begin
            in_ring.valid = 1'b0;
         end
         #1;
         if (out_local.valid && out_local_ready) begin
            if (exp_l.size() == 0) chk("loc_spurious", 32'd1, 32'd0);
            else begin
               e = exp_l.pop_front();
               chk("loc_flit", 32'({out_local.last, out_local.data}), 32'({e.last, e.data}));
            end
         end
         if (out_ring.valid && out_ring_ready) begin
            if (exp_r.size() == 0) chk("ring_spurious", 32'd1, 32'd0);
            else begin
               e = exp_r.pop_front();
               chk("ring_flit", 32'({out_ring.last, out_ring.data}), 32'({e.last, e.data}));
            end
         end
         acc = in_ring.valid && in_ring_ready;
         tick();
         if (acc) begin
            idx++;
            pres = 1'b0;
         end
      end
      chk("rand_drain", 32'(stim_q.size() - idx + exp_l.size() + exp_r.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
